// File: rtl/dpd_cfg_pkg.sv
// Shared types and constants for the DPD actuator LUT configuration path.
// The read latency default must track the actuator's validc pipeline depth.
package dpd_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    localparam int RD_LATENCY_DEF = 3;

endpackage

// File: rtl/dpd_cfg_csum.sv
// Clearable modular accumulator used for the write and read-back checksums.
// Clear wins over enable so a new load never inherits a stale partial sum.
module dpd_cfg_csum #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/dpd_lut_loader.sv
// Sequencer that writes one actuator LUT from a coefficient stream and can
// read it back, comparing write and read checksums.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; config port released
//   WRITE | accepting coefficients, one config write per accepted beat
//   READ  | issuing one read per cycle, address 0..last_addr
//   DRAIN | collecting outstanding returns, bounded by a timeout
//   DONE  | one-cycle done pulse, then back to IDLE
module dpd_lut_loader
    import dpd_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int ID_MAX     = 64,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int TIMEOUT    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [$clog2(ID_MAX)-1:0] lut_sel,
    input  logic [ADDR_WIDTH-1:0]     last_addr,
    input  logic                      verify_en,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    output logic                      enc,
    output logic [ID_MAX-1:0]         lutIdc,
    output logic                      wec,
    output logic [ADDR_WIDTH-1:0]     addrc,
    output logic [DATA_WIDTH-1:0]     dinc,
    input  logic [DATA_WIDTH-1:0]     doutc,
    input  logic                      validc,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam int SEL_W = $clog2(ID_MAX);
    localparam int TMR_W = $clog2(RD_LATENCY + TIMEOUT + 1);
    // The DRAIN cycle in which the timer reads zero is the last one tolerated,
    // so done lands RD_LATENCY+TIMEOUT cycles after the final read on the port.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RD_LATENCY + TIMEOUT - 1);

    state_t state_q, state_d;

    logic [SEL_W-1:0]      lut_sel_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  verify_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   rcnt_q;
    logic [ADDR_WIDTH:0]   n_entries;
    logic [TMR_W-1:0]      tmr_q;
    logic [ID_MAX-1:0]     lut_onehot;
    logic [DATA_WIDTH-1:0] wsum;
    logic [DATA_WIDTH-1:0] rsum;

    logic       at_last;
    logic       beat;
    logic       issue;
    logic       clr_all;
    logic       load_tmr;
    logic       rd_accept;
    logic       err_set;
    logic [1:0] err_code_d;

    assign at_last    = (addr_q == last_addr_q);
    assign n_entries  = {1'b0, last_addr_q} + (ADDR_WIDTH + 1)'(1);
    assign lut_onehot = ID_MAX'(1) << lut_sel_q;
    assign rd_accept  = validc && ((state_q == READ) || (state_q == DRAIN));
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        s_ready    = 1'b0;
        beat       = 1'b0;
        issue      = 1'b0;
        clr_all    = 1'b0;
        load_tmr   = 1'b0;
        err_set    = 1'b0;
        err_code_d = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_all = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    beat = 1'b1;
                    if (at_last) begin
                        state_d = verify_q ? READ : DONE;
                    end
                end
            end
            READ: begin
                issue = 1'b1;
                if (at_last) begin
                    state_d  = DRAIN;
                    load_tmr = 1'b1;
                end
            end
            DRAIN: begin
                if (rcnt_q == n_entries) begin
                    if (rsum != wsum) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = DONE;
                end else if (tmr_q == '0) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort also drops s_ready so the upstream beat offered this cycle is not consumed.
        if (abort && (state_q != IDLE)) begin
            state_d    = DONE;
            s_ready    = 1'b0;
            beat       = 1'b0;
            issue      = 1'b0;
            load_tmr   = 1'b0;
            err_set    = 1'b1;
            err_code_d = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_sel_q   <= '0;
            last_addr_q <= '0;
            verify_q    <= 1'b0;
            addr_q      <= '0;
            rcnt_q      <= '0;
            tmr_q       <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            if (clr_all) begin
                lut_sel_q   <= lut_sel;
                last_addr_q <= last_addr;
                verify_q    <= verify_en;
            end

            if (clr_all) begin
                addr_q <= '0;
            end else if (beat || issue) begin
                addr_q <= at_last ? '0 : addr_q + ADDR_WIDTH'(1);
            end

            if (clr_all) begin
                rcnt_q <= '0;
            end else if (rd_accept) begin
                rcnt_q <= rcnt_q + (ADDR_WIDTH + 1)'(1);
            end

            if (load_tmr) begin
                tmr_q <= TMR_LOAD;
            end else if ((state_q == DRAIN) && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TMR_W'(1);
            end

            if (clr_all) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else if (err_set) begin
                err      <= 1'b1;
                err_code <= err_code_d;
            end
        end
    end

    // Config port registers: addrc/dinc keep their last value between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc    <= 1'b0;
            wec    <= 1'b0;
            lutIdc <= '0;
            addrc  <= '0;
            dinc   <= '0;
        end else begin
            enc    <= beat || issue;
            wec    <= beat;
            lutIdc <= (beat || issue) ? lut_onehot : '0;
            if (beat || issue) begin
                addrc <= addr_q;
            end
            if (beat) begin
                dinc <= s_data;
            end
        end
    end

    dpd_cfg_csum #(.WIDTH(DATA_WIDTH)) u_wsum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_all),
        .en    (beat),
        .din   (s_data),
        .sum   (wsum)
    );

    dpd_cfg_csum #(.WIDTH(DATA_WIDTH)) u_rsum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_all),
        .en    (rd_accept),
        .din   (doutc),
        .sum   (rsum)
    );

endmodule

// File: tb/tb_dpd_lut_loader.sv
// Bench for dpd_lut_loader: table of directed loads against a small actuator
// model, plus hand-written abort, busy-start, IDLE start+abort and reset cases.
module tb_dpd_lut_loader;
    import dpd_cfg_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int IDM = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [5:0]     lut_sel = '0;
    logic [AW-1:0]  last_addr = '0;
    logic           verify_en = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic           enc;
    logic [IDM-1:0] lutIdc;
    logic           wec;
    logic [AW-1:0]  addrc;
    logic [DW-1:0]  dinc;
    logic [DW-1:0]  doutc;
    logic           validc;
    logic           busy;
    logic           done;
    logic           err;
    logic [1:0]     err_code;

    always #5 clk = ~clk;

    dpd_lut_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_MAX     (IDM),
        .RD_LATENCY (3),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .lut_sel   (lut_sel),
        .last_addr (last_addr),
        .verify_en (verify_en),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .enc       (enc),
        .lutIdc    (lutIdc),
        .wec       (wec),
        .addrc     (addrc),
        .dinc      (dinc),
        .doutc     (doutc),
        .validc    (validc),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    // Actuator model: stores writes, returns reads three cycles after they appear.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          respond = 1'b1;
    int            bad_addr = -1;
    logic [2:0]    pv;
    logic [DW-1:0] pd [0:2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            if (enc && wec) mem[addrc] <= dinc;
            pv    <= {pv[1:0], respond && enc && !wec};
            pd[0] <= (int'(addrc) == bad_addr) ? 32'h99 : mem[addrc];
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    assign validc = pv[2];
    assign doutc  = pd[2];

    typedef struct packed {
        logic           w;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic [IDM-1:0] l;
    } beat_t;

    beat_t log_q[$];
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    last_wr_cyc = 0;
    int    last_rd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enc) begin
            log_q.push_back(beat_t'({wec, addrc, dinc, lutIdc}));
            if (wec) last_wr_cyc = cyc;
            else     last_rd_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int k;
        s_valid = 1'b1;
        s_data  = d;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("s_ready_wait", 128'(s_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  k;
        logic got;
        got = 1'b0;
        k = 0;
        while (!got && k < 100) begin
            @(negedge clk);
            if (done) got = 1'b1;
            k++;
        end
        check(name, 128'(got), 128'(1'b1));
    endtask

    typedef struct {
        logic [5:0]    sel;
        logic [AW-1:0] last;
        logic          ver;
        logic          stall;
        logic          resp;
        int            bad;
        logic [DW-1:0] base;
        logic          exp_err;
        logic [1:0]    exp_code;
        int            delta;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int t);
        vec_t           v;
        int             n, base_log, base_done, nb;
        logic [IDM-1:0] oh;
        beat_t          e;
        v = vecs[t];
        n = int'(v.last) + 1;
        base_log  = log_q.size();
        base_done = done_cnt;
        oh = IDM'(1) << v.sel;
        respond  = v.resp;
        bad_addr = v.bad;
        lut_sel = v.sel; last_addr = v.last; verify_en = v.ver;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (v.stall && (i % 2 == 1)) begin
                s_valid = 1'b0;
                tick();
            end
            send_beat(v.base + DW'(i));
        end
        wait_done($sformatf("v%0d done_seen", t));
        check($sformatf("v%0d err", t), 128'(err), 128'(v.exp_err));
        check($sformatf("v%0d err_code", t), 128'(err_code), 128'(v.exp_code));
        tick();
        tick();
        check($sformatf("v%0d busy_idle", t), 128'(busy), 128'(1'b0));
        check($sformatf("v%0d done_pulses", t), 128'(done_cnt - base_done), 128'(1));
        nb = v.ver ? 2 * n : n;
        check($sformatf("v%0d beat_count", t), 128'(log_q.size() - base_log), 128'(nb));
        for (int i = 0; i < n; i++) begin
            e = beat_t'({1'b1, AW'(i), v.base + DW'(i), oh});
            if (base_log + i < log_q.size())
                check($sformatf("v%0d wr%0d", t, i), 128'(log_q[base_log + i]), 128'(e));
        end
        if (v.ver) begin
            for (int i = 0; i < n; i++) begin
                e = beat_t'({1'b0, AW'(i), v.base + DW'(n - 1), oh});
                if (base_log + n + i < log_q.size())
                    check($sformatf("v%0d rd%0d", t, i), 128'(log_q[base_log + n + i]), 128'(e));
            end
        end
        check($sformatf("v%0d done_delta", t),
              128'(v.ver ? done_cyc - last_rd_cyc : done_cyc - last_wr_cyc), 128'(v.delta));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_log, base_done;
        //            sel    last    ver   stall resp  bad base           err   code  delta
        vecs[0] = '{6'd5,  10'd3, 1'b0, 1'b0, 1'b1, -1, 32'h0000_0001, 1'b0, 2'd0, 0};
        vecs[1] = '{6'd5,  10'd3, 1'b0, 1'b1, 1'b1, -1, 32'h0000_0001, 1'b0, 2'd0, 0};
        vecs[2] = '{6'd63, 10'd7, 1'b1, 1'b0, 1'b1, -1, 32'h0000_0010, 1'b0, 2'd0, 5};
        vecs[3] = '{6'd63, 10'd7, 1'b1, 1'b0, 1'b1,  2, 32'h0000_0010, 1'b1, 2'd1, 5};
        vecs[4] = '{6'd0,  10'd0, 1'b1, 1'b0, 1'b1, -1, 32'hABCD_0000, 1'b0, 2'd0, 5};
        vecs[5] = '{6'd10, 10'd2, 1'b1, 1'b0, 1'b0, -1, 32'h0000_0100, 1'b1, 2'd2, 11};
        vecs[6] = '{6'd1,  10'd0, 1'b0, 1'b1, 1'b1, -1, 32'hFFFF_FFFF, 1'b0, 2'd0, 0};

        #12;
        check("reset_outputs",
              128'({enc, wec, lutIdc, addrc, dinc, busy, done, err, err_code, s_ready}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 7; t++) run_vec(t);

        // Abort on the third beat; an extra start while busy must not relatch anything.
        respond = 1'b1; bad_addr = -1;
        base_log = log_q.size();
        base_done = done_cnt;
        lut_sel = 6'd5; last_addr = 10'd7; verify_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_beat(32'hA0);
        lut_sel = 6'd9; last_addr = 10'd0; start = 1'b1;
        tick();
        start = 1'b0;
        send_beat(32'hA1);
        s_valid = 1'b1; s_data = 32'hA2; abort = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("abort_enc", 128'(enc), 128'(1'b0));
        check("abort_done", 128'(done), 128'(1'b1));
        check("abort_err", 128'({err, err_code}), 128'({1'b1, ERR_ABORT}));
        tick();
        tick();
        check("abort_busy", 128'(busy), 128'(1'b0));
        check("abort_beats", 128'(log_q.size() - base_log), 128'(2));
        if (log_q.size() >= base_log + 2)
            check("busy_start_ignored", 128'(log_q[base_log + 1]),
                  128'(beat_t'({1'b1, 10'd1, 32'hA1, 64'd1 << 5})));
        check("abort_done_pulses", 128'(done_cnt - base_done), 128'(1));

        // start and abort together in IDLE: the start wins and clears the sticky error.
        lut_sel = 6'd2; last_addr = 10'd0; verify_en = 1'b0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 128'(busy), 128'(1'b1));
        check("idle_abort_err_clr", 128'({err, err_code}), 128'(0));
        tick();
        send_beat(32'h55);
        wait_done("idle_abort_done");
        check("idle_abort_code", 128'({err, err_code}), 128'(0));
        tick();

        // Asynchronous reset while a write is on the port.
        lut_sel = 6'd3; last_addr = 10'd5; verify_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_beat(32'h1);
        s_valid = 1'b1; s_data = 32'h2;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_enc", 128'(enc), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              128'({enc, wec, lutIdc, addrc, dinc, busy, done, err, err_code, s_ready}), 128'(0));
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_vec(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
